// File: rtl/watch_display_scan_pkg.sv
// Shared constants for the stopwatch display scanner.
// Segment order is {g,f,e,d,c,b,a}; all patterns are active-high.
package watch_display_scan_pkg;

    localparam int NUM_DIGITS = 6;

    // Digits 1 and 3 carry the s.0 and min.s separators
    localparam logic [5:0] DP_MASK = 6'b001010;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam logic [2:0] LAST_DIGIT = 3'd5;

    // One-hot anode pattern for a digit index
    function automatic logic [5:0] digit_onehot(input logic [2:0] i);
        logic [5:0] r;
        r = 6'b000000;
        case (i)
            3'd0:    r = 6'b000001;
            3'd1:    r = 6'b000010;
            3'd2:    r = 6'b000100;
            3'd3:    r = 6'b001000;
            3'd4:    r = 6'b010000;
            3'd5:    r = 6'b100000;
            default: r = 6'b000000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/watch_display_scan_bcd_to_seg7.sv
// BCD to seven-segment decoder; non-BCD codes show a dash.
// Output is active-high {g,f,e,d,c,b,a}.
module bcd_to_seg7
    import watch_display_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure table lookup, anything above 9 renders as "-"
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/watch_display_scan.sv
// Multiplexes six latched BCD digits onto a 6-digit 7-seg display.
// A snapshot of the digits is taken once per frame so a frame never tears.
module watch_display_scan
    import watch_display_scan_pkg::*;
#(
    parameter int SCAN_DIV      = 100000,
    parameter int BLANK_CYCLES  = 1,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] q0,
    input  logic [3:0] q1,
    input  logic [3:0] q2,
    input  logic [3:0] q3,
    input  logic [3:0] q4,
    input  logic [3:0] q5,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] PRE_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] PRE_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] pre;
    logic [2:0]    idx;
    logic [3:0]    snap [NUM_DIGITS];

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    cur_bcd;
    logic [6:0]    cur_pat;
    logic          lead_blank;
    logic          in_blank;
    logic [5:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    logic [5:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;
    logic          tick_r;

    assign slot_end  = (pre == PRE_LAST);
    assign frame_end = slot_end && (idx == LAST_DIGIT);

    // Prescaler and digit index advance only while scanning is enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (en) begin
            if (slot_end) begin
                pre <= '0;
                idx <= (idx == LAST_DIGIT) ? 3'd0 : idx + 3'd1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    // Latch all digits together at the frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap[i] <= 4'd0;
            end
        end else if (en && frame_end) begin
            snap[0] <= q0;
            snap[1] <= q1;
            snap[2] <= q2;
            snap[3] <= q3;
            snap[4] <= q4;
            snap[5] <= q5;
        end
    end

    // Select the digit being scanned and its separator/blanking attributes
    always_comb begin
        cur_bcd    = snap[0];
        dp_next    = DP_MASK[0];
        lead_blank = 1'b0;
        case (idx)
            3'd0: begin
                cur_bcd = snap[0];
                dp_next = DP_MASK[0];
            end
            3'd1: begin
                cur_bcd = snap[1];
                dp_next = DP_MASK[1];
            end
            3'd2: begin
                cur_bcd = snap[2];
                dp_next = DP_MASK[2];
            end
            3'd3: begin
                cur_bcd = snap[3];
                dp_next = DP_MASK[3];
            end
            3'd4: begin
                cur_bcd    = snap[4];
                dp_next    = DP_MASK[4];
                lead_blank = BLANK_LEADING &&
                             (snap[5] == 4'd0) &&
                             (snap[4] == 4'd0);
            end
            3'd5: begin
                cur_bcd    = snap[5];
                dp_next    = DP_MASK[5];
                lead_blank = BLANK_LEADING &&
                             (snap[5] == 4'd0);
            end
            default: begin
                cur_bcd    = 4'd0;
                dp_next    = 1'b0;
                lead_blank = 1'b0;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (cur_bcd),
        .seg (cur_pat)
    );

    // Anodes stay dark for the first cycles of a slot to avoid ghosting
    always_comb begin
        in_blank = (pre < PRE_BLANK);
        an_next  = in_blank ? 6'b000000 : digit_onehot(idx);
        seg_next = lead_blank ? SEG_OFF : cur_pat;
    end

    // Registered outputs; disabling only darkens the anodes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r   <= 6'b000000;
            seg_r  <= SEG_OFF;
            dp_r   <= 1'b0;
            tick_r <= 1'b0;
        end else if (en) begin
            an_r   <= an_next;
            seg_r  <= seg_next;
            dp_r   <= dp_next;
            tick_r <= frame_end;
        end else begin
            an_r   <= 6'b000000;
            tick_r <= 1'b0;
        end
    end

    assign an         = an_r ^ {6{ACTIVE_LOW}};
    assign seg        = seg_r ^ {7{ACTIVE_LOW}};
    assign dp         = dp_r ^ ACTIVE_LOW;
    assign frame_tick = tick_r;

endmodule
